// File: rtl/gradient_dram_rmw_sink.sv
// Gradient backing store. Each writeback beat is added into the store through a 2-stage
// read-modify-write pipeline with hazard forwarding. The optimizer has a read / read-and-clear port.
// Optional build macro GRAD_SINK_SAT_EN: accumulates saturate instead of wrapping.
module gradient_dram_rmw_sink #(
  parameter int MEM_DEPTH = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dram_valid,
  input  logic [31:0]       dram_addr,
  input  logic [31:0]       dram_value,
  output logic              dram_ready,
  input  logic              rd_req,
  input  logic [31:0]       rd_addr,
  input  logic              rd_clear,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              init_done,
  output logic [CNT_W-1:0]  debug_wr_count,
  output logic [CNT_W-1:0]  debug_drop_count,
  output logic              debug_saturated
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] OP_ACC   = 2'd0;
  localparam logic [1:0] OP_RD    = 2'd1;
  localparam logic [1:0] OP_RDCLR = 2'd2;

  logic [0:0]        state;
  logic [ADDR_W-1:0] init_ptr;

  logic [31:0]       mem [MEM_DEPTH];
  logic [31:0]       mem_rdata;

  logic              running;
  logic              issue_valid;
  logic [1:0]        issue_op;
  logic [31:0]       issue_addr;
  logic              issue_in_range;
  logic [ADDR_W-1:0] issue_idx;

  logic              s0_valid;
  logic [1:0]        s0_op;
  logic              s0_in_range;
  logic [ADDR_W-1:0] s0_idx;
  logic [31:0]       s0_value;

  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_idx_q;
  logic [31:0]       wr_data_q;

  logic              fwd_hit;
  logic [31:0]       base;
  logic [31:0]       raw_sum;
  logic [31:0]       sum;
  logic              s1_wr_en;
  logic [31:0]       s1_wdata;

  // Issue slot: a read request always wins the cycle and back-pressures the writeback stream.
  always_comb begin
    running        = (state == ST_RUN);
    dram_ready     = running & ~rd_req;
    issue_valid    = running & (rd_req | dram_valid);
    issue_op       = rd_req ? (rd_clear ? OP_RDCLR : OP_RD) : OP_ACC;
    issue_addr     = rd_req ? rd_addr : dram_addr;
    issue_in_range = (issue_addr[31:ADDR_W] == '0);
    issue_idx      = issue_addr[ADDR_W-1:0];
  end

  assign init_done = running;

  // The RAM is read-before-write, so the write retiring in the same cycle as the next
  // read is invisible to it and must be forwarded from the registered write.
  always_comb begin
    fwd_hit  = wr_valid_q && (wr_idx_q == s0_idx);
    base     = fwd_hit ? wr_data_q : mem_rdata;
    raw_sum  = base + s0_value;
    s1_wr_en = s0_valid & s0_in_range & (s0_op != OP_RD);
  end

`ifdef GRAD_SINK_SAT_EN
  logic ovf;
  always_comb begin
    ovf             = (base[31] == s0_value[31]) && (raw_sum[31] != base[31]);
    sum             = ovf ? (base[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : raw_sum;
    debug_saturated = s0_valid & s0_in_range & (s0_op == OP_ACC) & ovf;
  end
`else
  always_comb begin
    sum             = raw_sum;
    debug_saturated = 1'b0;
  end
`endif

  assign s1_wdata = (s0_op == OP_ACC) ? sum : 32'h0;

  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_ptr] <= '0;
    end else if (s1_wr_en) begin
      mem[s0_idx] <= s1_wdata;
    end
    mem_rdata <= mem[issue_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_INIT;
      init_ptr         <= '0;
      s0_valid         <= 1'b0;
      s0_op            <= OP_ACC;
      s0_in_range      <= 1'b0;
      s0_idx           <= '0;
      s0_value         <= '0;
      wr_valid_q       <= 1'b0;
      wr_idx_q         <= '0;
      wr_data_q        <= '0;
      rd_valid         <= 1'b0;
      rd_data          <= '0;
      debug_wr_count   <= '0;
      debug_drop_count <= '0;
    end else begin
      if (state == ST_INIT) begin
        init_ptr <= init_ptr + 1'b1;
        if (init_ptr == ADDR_W'(MEM_DEPTH - 1)) begin
          state <= ST_RUN;
        end
      end

      s0_valid    <= issue_valid;
      s0_op       <= issue_op;
      s0_in_range <= issue_in_range;
      s0_idx      <= issue_idx;
      s0_value    <= dram_value;

      wr_valid_q  <= s1_wr_en;
      wr_idx_q    <= s0_idx;
      wr_data_q   <= s1_wdata;

      rd_valid <= s0_valid & (s0_op != OP_ACC);
      if (s0_valid && (s0_op != OP_ACC)) begin
        rd_data <= s0_in_range ? base : 32'h0;
      end

      if (s0_valid && s0_in_range && (s0_op == OP_ACC)) begin
        debug_wr_count <= debug_wr_count + CNT_W'(1);
      end
      if (s0_valid && !s0_in_range) begin
        debug_drop_count <= debug_drop_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gradient_dram_rmw_sink.sv
// Directed bench for gradient_dram_rmw_sink: init sweep, accumulate/forward table,
// read priority with clear, range drops, overflow and mid-stream reset.
module tb_gradient_dram_rmw_sink;

  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_BEAT = 2'd1;
  localparam logic [1:0] K_RD   = 2'd2;

`ifdef GRAD_SINK_SAT_EN
  localparam logic [31:0] OVF_RESULT = 32'h7FFF_FFFF;
  localparam logic        OVF_PULSE  = 1'b1;
`else
  localparam logic [31:0] OVF_RESULT = 32'h8000_0000;
  localparam logic        OVF_PULSE  = 1'b0;
`endif

  typedef struct {
    logic [1:0]  kind;
    logic        clr;
    logic [31:0] addr;
    logic [31:0] value;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_sat;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        dram_valid;
  logic [31:0] dram_addr;
  logic [31:0] dram_value;
  logic        dram_ready;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_clear;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        init_done;
  logic [15:0] debug_wr_count;
  logic [15:0] debug_drop_count;
  logic        debug_saturated;

  int tests;
  int fails;

  gradient_dram_rmw_sink dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dram_valid       (dram_valid),
    .dram_addr        (dram_addr),
    .dram_value       (dram_value),
    .dram_ready       (dram_ready),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_clear         (rd_clear),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .init_done        (init_done),
    .debug_wr_count   (debug_wr_count),
    .debug_drop_count (debug_drop_count),
    .debug_saturated  (debug_saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] kind, input logic clr, input logic [31:0] addr,
                              input logic [31:0] value, input logic ev, input logic [31:0] ed,
                              input logic es);
    vec_t v;
    v.kind = kind; v.clr = clr; v.addr = addr; v.value = value;
    v.exp_valid = ev; v.exp_data = ed; v.exp_sat = es;
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rd_req     = (v.kind == K_RD);
    rd_clear   = v.clr;
    rd_addr    = v.addr;
    dram_valid = (v.kind == K_BEAT);
    dram_addr  = v.addr;
    dram_value = v.value;
  endtask

  task automatic idleInputs();
    applyStimulus(mk(K_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
  endtask

  // Counts edges until init_done, flagging any early ready/done, with a hard cycle bound.
  task automatic waitInit(input int expected, input string name);
    int n;
    int early;
    n = 0;
    early = 0;
    while (!init_done && n < 2000) begin
      if (dram_ready !== 1'b0 || rd_valid !== 1'b0) early++;
      cycle();
      n++;
    end
    checkOutput({name, "_init_cycles"}, 32'(n), 32'(expected));
    checkOutput({name, "_ready_during_init"}, 32'(early), 32'd0);
    checkOutput({name, "_ready_after_init"}, {31'd0, dram_ready}, 32'd1);
  endtask

  task automatic readCheck(input logic [31:0] addr, input logic [31:0] expected, input string name);
    applyStimulus(mk(K_RD, 1'b0, addr, 32'h0, 1'b0, 32'h0, 1'b0));
    cycle();
    idleInputs();
    cycle();
    checkOutput({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
    checkOutput({name, "_data"}, rd_data, expected);
  endtask

  vec_t vecs[25];

  initial begin
    tests = 0;
    fails = 0;

    vecs[0]  = mk(K_RD,   1'b0, 32'd5,     32'd0,          1'b1, 32'd0,  1'b0);
    vecs[1]  = mk(K_RD,   1'b0, 32'd3,     32'd0,          1'b1, 32'd0,  1'b0);
    vecs[2]  = mk(K_RD,   1'b0, 32'd1023,  32'd0,          1'b1, 32'd0,  1'b0);
    vecs[3]  = mk(K_BEAT, 1'b0, 32'd5,     32'd100,        1'b0, 32'd0,  1'b0);
    vecs[4]  = mk(K_BEAT, 1'b0, 32'd5,     32'hFFFF_FFE2,  1'b0, 32'd0,  1'b0);
    vecs[5]  = mk(K_RD,   1'b0, 32'd5,     32'd0,          1'b1, 32'd70, 1'b0);
    vecs[6]  = mk(K_BEAT, 1'b0, 32'd7,     32'd1,          1'b0, 32'd0,  1'b0);
    vecs[7]  = mk(K_BEAT, 1'b0, 32'd7,     32'd1,          1'b0, 32'd0,  1'b0);
    vecs[8]  = mk(K_BEAT, 1'b0, 32'd7,     32'd1,          1'b0, 32'd0,  1'b0);
    vecs[9]  = mk(K_BEAT, 1'b0, 32'd7,     32'd1,          1'b0, 32'd0,  1'b0);
    vecs[10] = mk(K_RD,   1'b0, 32'd7,     32'd0,          1'b1, 32'd4,  1'b0);
    vecs[11] = mk(K_BEAT, 1'b0, 32'd8,     32'd1,          1'b0, 32'd0,  1'b0);
    vecs[12] = mk(K_BEAT, 1'b0, 32'd8,     32'd1,          1'b0, 32'd0,  1'b0);
    vecs[13] = mk(K_RD,   1'b0, 32'd8,     32'd0,          1'b1, 32'd2,  1'b0);
    vecs[14] = mk(K_BEAT, 1'b0, 32'd8,     32'd1,          1'b0, 32'd0,  1'b0);
    vecs[15] = mk(K_BEAT, 1'b0, 32'd8,     32'd1,          1'b0, 32'd0,  1'b0);
    vecs[16] = mk(K_RD,   1'b0, 32'd8,     32'd0,          1'b1, 32'd4,  1'b0);
    vecs[17] = mk(K_BEAT, 1'b0, 32'h400,   32'd55,         1'b0, 32'd0,  1'b0);
    vecs[18] = mk(K_RD,   1'b0, 32'h400,   32'd0,          1'b1, 32'd0,  1'b0);
    vecs[19] = mk(K_RD,   1'b0, 32'd0,     32'd0,          1'b1, 32'd0,  1'b0);
    vecs[20] = mk(K_BEAT, 1'b0, 32'd9,     32'h7FFF_FFFF,  1'b0, 32'd0,  1'b0);
    vecs[21] = mk(K_BEAT, 1'b0, 32'd9,     32'd1,          1'b0, 32'd0,  OVF_PULSE);
    vecs[22] = mk(K_RD,   1'b0, 32'd9,     32'd0,          1'b1, OVF_RESULT, 1'b0);
    vecs[23] = mk(K_IDLE, 1'b0, 32'd0,     32'd0,          1'b0, 32'd0,  1'b0);
    vecs[24] = mk(K_IDLE, 1'b0, 32'd0,     32'd0,          1'b0, 32'd0,  1'b0);

    rst_n = 1'b0;
    idleInputs();
    cycle();
    cycle();
    checkOutput("rst_dram_ready", {31'd0, dram_ready}, 32'd0);
    checkOutput("rst_rd_valid",   {31'd0, rd_valid},   32'd0);
    checkOutput("rst_rd_data",    rd_data,             32'd0);
    checkOutput("rst_init_done",  {31'd0, init_done},  32'd0);
    checkOutput("rst_wr_count",   32'(debug_wr_count),   32'd0);
    checkOutput("rst_drop_count", 32'(debug_drop_count), 32'd0);

    // Traffic during INIT must be ignored entirely.
    rst_n = 1'b1;
    applyStimulus(mk(K_BEAT, 1'b0, 32'd3, 32'd99, 1'b0, 32'd0, 1'b0));
    rd_req  = 1'b1;
    rd_addr = 32'd3;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkOutput("init_ignores_rd", {31'd0, rd_valid}, 32'd0);
    end
    idleInputs();
    waitInit(1024 - 5, "first");

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_ready", i), {31'd0, dram_ready}, {31'd0, vecs[i].kind != K_RD});
      cycle();
      checkOutput($sformatf("v%0d_sat", i), {31'd0, debug_saturated}, {31'd0, vecs[i].exp_sat});
      if (i > 0) begin
        checkOutput($sformatf("v%0d_rd_valid", i - 1), {31'd0, rd_valid}, {31'd0, vecs[i-1].exp_valid});
        if (vecs[i-1].exp_valid) begin
          checkOutput($sformatf("v%0d_rd_data", i - 1), rd_data, vecs[i-1].exp_data);
        end
      end
    end
    checkOutput("table_wr_count",   32'(debug_wr_count),   32'd12);
    checkOutput("table_drop_count", 32'(debug_drop_count), 32'd2);

    // Read-and-clear wins the slot over a pending beat; the beat goes next cycle.
    applyStimulus(mk(K_BEAT, 1'b0, 32'd6, 32'd3, 1'b0, 32'd0, 1'b0));
    rd_req   = 1'b1;
    rd_clear = 1'b1;
    rd_addr  = 32'd5;
    #1;
    checkOutput("prio_ready_low", {31'd0, dram_ready}, 32'd0);
    cycle();
    rd_req   = 1'b0;
    rd_clear = 1'b0;
    #1;
    checkOutput("prio_ready_high", {31'd0, dram_ready}, 32'd1);
    cycle();
    idleInputs();
    checkOutput("prio_clr_valid", {31'd0, rd_valid}, 32'd1);
    checkOutput("prio_clr_data",  rd_data,             32'd70);
    cycle();
    readCheck(32'd5, 32'd0, "after_clear_5");
    readCheck(32'd6, 32'd3, "deferred_beat_6");
    checkOutput("prio_wr_count", 32'(debug_wr_count), 32'd13);

    // Reset while an accumulate sits in the write stage: the write must not land.
    applyStimulus(mk(K_BEAT, 1'b0, 32'd6, 32'd9, 1'b0, 32'd0, 1'b0));
    cycle();
    rst_n = 1'b0;
    idleInputs();
    #1;
    checkOutput("midrst_init_done",  {31'd0, init_done}, 32'd0);
    checkOutput("midrst_ready",      {31'd0, dram_ready}, 32'd0);
    checkOutput("midrst_rd_data",    rd_data,             32'd0);
    checkOutput("midrst_wr_count",   32'(debug_wr_count),   32'd0);
    checkOutput("midrst_drop_count", 32'(debug_drop_count), 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    waitInit(1024, "second");
    readCheck(32'd6, 32'd0, "post_rst_6");
    readCheck(32'd7, 32'd0, "post_rst_7");
    readCheck(32'd9, 32'd0, "post_rst_9");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
